// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// arb_types
//   Shared types for the two-requester memory arbiter.
//   arb_state_t : arbiter FSM state (idle, serving instruction port, serving
//                 data port).
//   requester_t : identity of a requester; used to remember which port was
//                 granted most recently so contention alternates.
// -----------------------------------------------------------------------------
package arb_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

endpackage : arb_types

// File: rtl/mem_arbiter_chk.sv
// -----------------------------------------------------------------------------
// mem_arbiter_chk
//   Protocol checker for mem_arbiter: the memory is never asked to read and
//   write at once, and a response is never forwarded to both ports.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   mem_read, mem_write : shared memory request strobes
//   i_resp, d_resp      : forwarded completions
// -----------------------------------------------------------------------------
module mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic mem_read,
    input logic mem_write,
    input logic i_resp,
    input logic d_resp
);

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(mem_read && mem_write));

    a_resp_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(i_resp && d_resp));

endmodule : mem_arbiter_chk

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Places one shared memory port (mem_read/mem_write/mem_resp handshake)
//   behind an instruction-fetch port and a data port. One requester is granted
//   at a time; on contention the requester that was not served last wins.
//   While granted, the handshake is passed through combinationally. Saturating
//   grant counters and sticky protocol-error flags are kept for observation.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   i_read, i_address        : instruction read request (held until i_resp)
//   i_rdata, i_resp          : instruction read data / completion
//   d_read, d_write          : data read / write request (held until d_resp)
//   d_address, d_wdata,
//   d_byte_enable            : data request payload
//   d_rdata, d_resp          : data read data / completion
//   mem_read, mem_write,
//   mem_address, mem_wdata,
//   mem_byte_enable          : shared memory request
//   mem_rdata, mem_resp      : shared memory response
//   i_grants, d_grants       : saturating grant counters
//   proto_err                : sticky [0] d_read&&d_write seen,
//                                     [1] mem_resp while nothing granted
// -----------------------------------------------------------------------------
module mem_arbiter
    import arb_types::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_read,
    input  logic [ADDR_WIDTH-1:0]   i_address,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    output logic                    i_resp,

    input  logic                    d_read,
    input  logic                    d_write,
    input  logic [ADDR_WIDTH-1:0]   d_address,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    d_resp,

    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_resp,

    output logic [CNT_WIDTH-1:0]    i_grants,
    output logic [CNT_WIDTH-1:0]    d_grants,
    output logic [1:0]              proto_err
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    arb_state_t             r_state;
    arb_state_t             w_next_state;
    requester_t             r_last_grant;
    logic [CNT_WIDTH-1:0]   r_i_grants;
    logic [CNT_WIDTH-1:0]   r_d_grants;
    logic [1:0]             r_proto_err;

    logic                   w_i_req;
    logic                   w_d_req;
    logic                   w_grant_i;
    logic                   w_grant_d;
    logic                   w_done_i;
    logic                   w_done_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Completion of the current grant; only a response inside a grant counts.
    assign w_done_i = (r_state == SERVE_I) & mem_resp;
    assign w_done_d = (r_state == SERVE_D) & mem_resp;

    // Next-state and grant decision.
    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) begin
                    // Contention: favour whoever was not served last.
                    if (r_last_grant == REQ_D) begin
                        w_next_state = SERVE_I;
                        w_grant_i    = 1'b1;
                    end else begin
                        w_next_state = SERVE_D;
                        w_grant_d    = 1'b1;
                    end
                end else if (w_i_req) begin
                    w_next_state = SERVE_I;
                    w_grant_i    = 1'b1;
                end else if (w_d_req) begin
                    w_next_state = SERVE_D;
                    w_grant_d    = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SERVE_I: begin
                // Held until the memory answers, even if the request drops.
                if (mem_resp) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = SERVE_I;
                end
            end
            SERVE_D: begin
                if (mem_resp) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = SERVE_D;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Remember the most recently served requester; reset value lets I win first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_grant <= REQ_D;
        end else if (w_done_i) begin
            r_last_grant <= REQ_I;
        end else if (w_done_d) begin
            r_last_grant <= REQ_D;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Instruction grant counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_grants <= {CNT_WIDTH{1'b0}};
        end else if (w_grant_i) begin
            r_i_grants <= f_sat_inc(r_i_grants);
        end else begin
            r_i_grants <= r_i_grants;
        end
    end

    // Data grant counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d_grants <= {CNT_WIDTH{1'b0}};
        end else if (w_grant_d) begin
            r_d_grants <= f_sat_inc(r_d_grants);
        end else begin
            r_d_grants <= r_d_grants;
        end
    end

    // Sticky protocol-error flags; cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_proto_err <= 2'b00;
        end else begin
            r_proto_err[0] <= r_proto_err[0] | (d_read & d_write);
            r_proto_err[1] <= r_proto_err[1] | (mem_resp & (r_state == IDLE));
        end
    end

    // Handshake routing: the granted port sees memory, the other sees zeros.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = {ADDR_WIDTH{1'b0}};
        mem_wdata       = {DATA_WIDTH{1'b0}};
        mem_byte_enable = {BE_WIDTH{1'b0}};
        i_rdata         = {DATA_WIDTH{1'b0}};
        i_resp          = 1'b0;
        d_rdata         = {DATA_WIDTH{1'b0}};
        d_resp          = 1'b0;
        case (r_state)
            SERVE_I: begin
                mem_read        = 1'b1;
                mem_address     = i_address;
                mem_byte_enable = {BE_WIDTH{1'b1}};
                i_rdata         = mem_rdata;
                i_resp          = mem_resp;
            end
            SERVE_D: begin
                // A simultaneous read+write request is served as a read only.
                mem_read        = d_read;
                mem_write       = d_write & ~d_read;
                mem_address     = d_address;
                mem_wdata       = d_wdata;
                mem_byte_enable = d_byte_enable;
                d_rdata         = mem_rdata;
                d_resp          = mem_resp;
            end
            default: begin
                mem_read        = 1'b0;
            end
        endcase
    end

    assign i_grants  = r_i_grants;
    assign d_grants  = r_d_grants;
    assign proto_err = r_proto_err;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [DW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_byte_enable;
    logic [DW-1:0] d_rdata;
    logic          d_resp;
    logic          mem_read;
    logic          mem_write;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_byte_enable;
    logic [DW-1:0] mem_rdata;
    logic          mem_resp;
    logic [CW-1:0] i_grants;
    logic [CW-1:0] d_grants;
    logic [1:0]    proto_err;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .i_grants(i_grants), .d_grants(d_grants), .proto_err(proto_err)
    );

    mem_arbiter_chk chk_u (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .i_resp(i_resp), .d_resp(d_resp)
    );

    typedef struct {
        logic          is_d;
        logic [31:0]   addr;
        logic          rd;
        logic          wr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic [31:0]   rdata;
    } exp_t;

    exp_t exp_q[$];

    int n_chk   = 0;
    int n_err   = 0;
    int cyc     = 0;
    int rd_hi   = 0;
    int n_resp  = 0;
    int resp_cyc = 0;
    int g_lat   = 3;
    int inj_req = 0;
    int inj_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        logic [31:0] r;
        if (a == 32'h0000_0060) r = 32'h0000_0013;
        else                    r = a ^ 32'h5A5A_0000;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_i(input logic [31:0] a, input logic [31:0] rdata);
        exp_t e;
        e.is_d = 1'b0; e.addr = a; e.rd = 1'b1; e.wr = 1'b0;
        e.wdata = 32'h0; e.be = 4'hF; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] a, input logic rd, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] rdata);
        exp_t e;
        e.is_d = 1'b1; e.addr = a; e.rd = rd; e.wr = wr;
        e.wdata = wdata; e.be = be; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Memory responder: answers g_lat cycles after the request first appears,
    // or injects a stray response on request.
    initial begin : responder
        int busy;
        busy = 0;
        mem_resp = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_resp = 1'b0;
            mem_rdata = 32'h0;
            if (inj_req != inj_done) begin
                inj_done++;
                mem_resp = 1'b1;
                mem_rdata = 32'hBAD0_0000;
            end else if (mem_read || mem_write) begin
                busy++;
                if (busy == g_lat + 1) begin
                    mem_resp = 1'b1;
                    mem_rdata = mem_read ? mem_model(mem_address) : 32'h0;
                    busy = 0;
                end
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: every forwarded response is matched against the scoreboard.
    initial begin : monitor
        exp_t e;
        logic prev_resp;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (mem_read) rd_hi++;
                if (prev_resp) chk("bubble_after_resp", {mem_read, mem_write}, 2'b00);
                if (i_resp || d_resp) begin
                    n_resp++;
                    resp_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("resp_with_empty_queue", {i_resp, d_resp}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_port", {i_resp, d_resp}, e.is_d ? 2'b01 : 2'b10);
                        if (e.is_d) begin
                            chk("d_rdata", d_rdata, e.rdata);
                            chk("i_quiet", {i_resp, i_rdata}, 33'h0);
                        end else begin
                            chk("i_rdata", i_rdata, e.rdata);
                            chk("d_quiet", {d_resp, d_rdata}, 33'h0);
                        end
                        chk("mem_address", mem_address, e.addr);
                        chk("mem_rw", {mem_read, mem_write}, {e.rd, e.wr});
                        chk("mem_wdata", mem_wdata, e.wdata);
                        chk("mem_be", mem_byte_enable, e.be);
                    end
                end
                prev_resp = i_resp || d_resp;
            end else begin
                prev_resp = 1'b0;
            end
        end
    end

    task automatic i_txn(input logic [31:0] a);
        int k;
        i_read = 1'b1;
        i_address = a;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (i_resp) break;
        end
        if (k == 100) chk("i_resp_timeout", i_resp, 1'b1);
        @(posedge clk);
        #1;
        i_read = 1'b0;
        i_address = 32'h0;
    endtask

    task automatic d_txn(input logic [31:0] a, input logic rd, input logic wr,
                         input logic [31:0] wdata, input logic [3:0] be);
        int k;
        d_read = rd;
        d_write = wr;
        d_address = a;
        d_wdata = wdata;
        d_byte_enable = be;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (d_resp) break;
        end
        if (k == 100) chk("d_resp_timeout", d_resp, 1'b1);
        @(posedge clk);
        #1;
        d_read = 1'b0;
        d_write = 1'b0;
        d_address = 32'h0;
        d_wdata = 32'h0;
        d_byte_enable = 4'h0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin : stimulus
        int c0;
        int r0;
        int n0;
        logic [31:0] a;
        rst = 1'b0;
        i_read = 1'b0; i_address = 32'h0;
        d_read = 1'b0; d_write = 1'b0; d_address = 32'h0;
        d_wdata = 32'h0; d_byte_enable = 4'h0;

        // Reset state, even with a request pending.
        #12;
        i_read = 1'b1; i_address = 32'h0000_0044;
        @(posedge clk); #1;
        chk("rst_mem_rw", {mem_read, mem_write}, 2'b00);
        chk("rst_mem_addr", mem_address, 32'h0);
        chk("rst_counters", {i_grants, d_grants}, 8'h00);
        chk("rst_proto_err", proto_err, 2'b00);
        chk("rst_resp", {i_resp, d_resp}, 2'b00);
        i_read = 1'b0; i_address = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // Lone instruction read, memory answers on the fourth cycle.
        g_lat = 3;
        c0 = cyc; r0 = rd_hi;
        push_i(32'h0000_0060, 32'h0000_0013);
        i_txn(32'h0000_0060);
        chk("t1_resp_cycle", resp_cyc - c0, 64'd4);
        chk("t1_read_cycles", rd_hi - r0, 64'd4);
        chk("t1_i_grants", i_grants, 4'd1);

        // Simultaneous I read and D write from reset: I first, then D.
        do_reset();
        g_lat = 1;
        push_i(32'h0000_0040, 32'h5A5A_0040);
        push_d(32'h0000_0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
        fork
            i_txn(32'h0000_0040);
            d_txn(32'h0000_0100, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF);
        join
        chk("t2_grants", {i_grants, d_grants}, {4'd1, 4'd1});

        // Ten back-to-back contended transactions alternate I, D, I, D ...
        do_reset();
        g_lat = 2;
        for (int k = 0; k < 5; k++) begin
            a = 32'h1000 + k * 4;
            push_i(a, mem_model(a));
            a = 32'h2000 + k * 4;
            if (k % 2 == 0) push_d(a, 1'b1, 1'b0, 32'h0, 4'hF, mem_model(a));
            else            push_d(a, 1'b0, 1'b1, 32'hC0DE_0000 + k, 4'hC, 32'h0);
        end
        fork
            begin
                for (int k = 0; k < 5; k++) i_txn(32'h1000 + k * 4);
            end
            begin
                for (int j = 0; j < 5; j++) begin
                    if (j % 2 == 0) d_txn(32'h2000 + j * 4, 1'b1, 1'b0, 32'h0, 4'hF);
                    else            d_txn(32'h2000 + j * 4, 1'b0, 1'b1, 32'hC0DE_0000 + j, 4'hC);
                end
            end
        join
        chk("t3_grants", {i_grants, d_grants}, {4'd5, 4'd5});

        // Stray memory response while idle is swallowed and flagged.
        n0 = n_resp;
        inj_req++;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_no_forward", n_resp - n0, 64'd0);
        chk("t4_proto_err", proto_err, 2'b10);

        // Data read+write together: served as a read, error flagged.
        push_d(32'h0000_0200, 1'b1, 1'b0, 32'h0000_1234, 4'hF, 32'h5A5A_0200);
        d_txn(32'h0000_0200, 1'b1, 1'b1, 32'h0000_1234, 4'hF);
        chk("t5_proto_err", proto_err, 2'b11);
        chk("t5_d_grants", d_grants, 4'd6);

        // Grant counter saturates at all-ones.
        g_lat = 0;
        for (int k = 0; k < 17; k++) begin
            a = 32'h3000 + k * 4;
            push_i(a, mem_model(a));
            i_txn(a);
        end
        chk("sat_i_grants", i_grants, 4'hF);
        chk("sat_d_grants", d_grants, 4'd6);

        // Reset in the middle of a data grant.
        g_lat = 10;
        d_read = 1'b1; d_address = 32'h0000_0300; d_byte_enable = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_pre_mem_read", mem_read, 1'b1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        d_read = 1'b0; d_address = 32'h0; d_byte_enable = 4'h0;
        #1;
        chk("t6_async_mem", {mem_read, mem_write, mem_address, mem_byte_enable}, 38'h0);
        chk("t6_async_counters", {i_grants, d_grants}, 8'h00);
        chk("t6_async_proto_err", proto_err, 2'b00);
        @(posedge clk);
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        g_lat = 2;
        push_i(32'h0000_0400, 32'h5A5A_0400);
        push_d(32'h0000_0500, 1'b1, 1'b0, 32'h0, 4'hF, 32'h5A5A_0500);
        fork
            i_txn(32'h0000_0400);
            d_txn(32'h0000_0500, 1'b1, 1'b0, 32'h0, 4'hF);
        join
        chk("t6_grants", {i_grants, d_grants}, {4'd1, 4'd1});
        inj_req++;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_late_resp_err", proto_err, 2'b10);

        repeat (2) @(posedge clk);
        chk("queue_drained", exp_q.size(), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter placing a single shared physical memory port (`mem_read`/`mem_write`/`mem_resp` handshake, as driven by the `mp2` core) behind an instruction-fetch port and a data port. It grants one requester at a time with round-robin priority on contention, passes the handshake through unchanged while granted, and keeps grant counters and sticky protocol-error flags for the bench. It sits between the core (or its I/D caches) and the top-level memory interface.

## Interface
- `ADDR_WIDTH`, 32, memory address width
- `DATA_WIDTH`, 32, data bus width; byte enable is `DATA_WIDTH/8`
- `CNT_WIDTH`, 32, width of each grant counter
- `clk` in 1 — single clock; all state changes on rising edge
- `rst` in 1 — asynchronous, active-low reset
- `i_read` in 1 — instruction read request, held until `i_resp`
- `i_address` in ADDR_WIDTH — instruction address
- `i_rdata` out DATA_WIDTH — instruction read data
- `i_resp` out 1 — instruction transaction complete
- `d_read`, `d_write` in 1 each — data read / write request, held until `d_resp`
- `d_address` in ADDR_WIDTH; `d_wdata` in DATA_WIDTH; `d_byte_enable` in DATA_WIDTH/8
- `d_rdata` out DATA_WIDTH; `d_resp` out 1
- `mem_read`, `mem_write` out 1 each; `mem_address` out ADDR_WIDTH; `mem_wdata` out DATA_WIDTH; `mem_byte_enable` out DATA_WIDTH/8
- `mem_rdata` in DATA_WIDTH; `mem_resp` in 1
- `i_grants`, `d_grants` out CNT_WIDTH — saturating grant counters
- `proto_err` out 2 — sticky: [0] `d_read && d_write` seen, [1] `mem_resp` outside a grant

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`.
- `IDLE`: i request = `i_read`; d request = `d_read | d_write`. One requester → go to its SERVE state. Both → grant the one not last granted (`last_grant`, reset value = D, so I wins first contention). Neither → stay.
- Grant increments that requester's counter; saturates at all-ones.
- `SERVE_I`: `mem_read=1`, `mem_write=0`, `mem_address=i_address`, `mem_byte_enable=all-ones`, `mem_wdata=0`; `i_rdata=mem_rdata`, `i_resp=mem_resp`.
- `SERVE_D`: `mem_read=d_read`, `mem_write=d_write & ~d_read` (read wins, never both), address/wdata/byte_enable from d port; `d_rdata=mem_rdata`, `d_resp=mem_resp`.
- On `mem_resp` in a SERVE state → `IDLE`, `last_grant` updated to the served requester.
- Non-granted requester: `*_resp=0`, `*_rdata=0`; its request is held, never dropped.
- `mem_resp` in `IDLE`: not forwarded; sets `proto_err[1]`.
- `d_read && d_write` in any cycle: sets `proto_err[0]`.
- Requester dropping request mid-grant: arbiter stays granted until `mem_resp` (request is illegal to drop; no recovery beyond that).

## Timing
- Reset (async, `rst=0`): state `IDLE`, `last_grant=D`, counters 0, `proto_err=0`; all outputs 0 immediately.
- Request first high in `IDLE` at edge N → `mem_read/write` asserted from cycle N+1 (one-cycle grant latency).
- `mem_resp` at cycle M → `*_resp` and `*_rdata` in the same cycle M (combinational); `mem_read/write` low from M+1.
- Cycle M+1 is always `IDLE` (one-cycle bubble); next grant drives memory from M+2 at the earliest.
- Requesters deassert or renew request at edge M+1.
- Reset mid-transaction: memory signals drop asynchronously; a later `mem_resp` sets `proto_err[1]`.
- `mem_read` and `mem_write` never high in the same cycle.

## Structure
- Package `arb_types`: `arb_state_t` enum (`IDLE`, `SERVE_I`, `SERVE_D`), `requester_t` enum (`REQ_I`, `REQ_D`).
- Single module; grant decision inline. No sub-module; counters are two instances of one always block pattern.

## Test plan
- Lone i read of 0x0000_0060, memory resp after 3 cycles with 0x0000_0013 → `mem_read` high cycles 1–4, `i_rdata=0x13` with `i_resp` on cycle 4, `i_grants=1`.
- `i_read` and `d_write` (addr 0x100, wdata 0xDEAD_BEEF, be 0xF) both high at cycle 0 → I served first, then D; `mem_write` with 0xDEAD_BEEF after the bubble; `d_grants=1`.
- Both requesters continuously active for 10 transactions → strict alternation I,D,I,D…; counters 5/5; `mem_read&&mem_write` never.
- `mem_resp` pulse while `IDLE` → no `*_resp`; `proto_err=2'b10` until reset.
- `d_read=d_write=1` on 0x200 → only `mem_read` asserted; `proto_err[0]=1`.
- `rst` low for 1 cycle mid-`SERVE_D` → all memory outputs 0 asynchronously, counters 0, next i request granted first.
